// File: rtl/msrv32_instr_fetch_buffer.sv
// Instruction-fetch front end: issues sequential word fetches, buffers in-order
// responses in a small FIFO and discards stale words after a branch redirect.
module msrv32_instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        stall_in,
  output logic [31:0] ms_riscv32_mp_imaddr_out,
  output logic        ms_riscv32_mp_instr_req_out,
  input  logic        ms_riscv32_mp_instr_gnt_in,
  input  logic        ms_riscv32_mp_instr_rvalid_in,
  input  logic [31:0] ms_riscv32_mp_instr_rdata_in,
  output logic [31:0] ms_riscv32_mp_instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pend_rd_q, pend_rd_d;
  logic [PW-1:0] pend_wr_q, pend_wr_d;

  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];
  logic [31:0] pend_pc_q   [DEPTH];

  logic [CW:0] occupancy;
  logic        fifo_empty;
  logic        issue;
  logic        resp_valid;
  logic        resp_drop;
  logic        push;
  logic        pop;

  // Every word in the FIFO or in flight holds a reserved slot, so a push can never overflow.
  assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign fifo_empty = (count_q == '0);

  assign ms_riscv32_mp_instr_req_out = !ms_riscv32_mp_rst_in && !branch_taken_in &&
                                       (occupancy < (CW+1)'(DEPTH));
  assign ms_riscv32_mp_imaddr_out    = pc_q;

  assign issue      = ms_riscv32_mp_instr_req_out && ms_riscv32_mp_instr_gnt_in;
  assign resp_valid = ms_riscv32_mp_instr_rvalid_in && (outstanding_q != '0);
  assign resp_drop  = resp_valid && (drop_q != '0);
  assign push       = resp_valid && !resp_drop && !branch_taken_in;
  assign pop        = !fifo_empty && !stall_in && !branch_taken_in;

  // Outputs depend only on FIFO state and the redirect, never on memory inputs.
  always_comb begin
    if (fifo_empty || branch_taken_in) begin
      ms_riscv32_mp_instr_out = NOP;
      pc_out                  = 32'h0000_0000;
      flush_out               = 1'b1;
    end else begin
      ms_riscv32_mp_instr_out = fifo_data_q[rd_ptr_q];
      pc_out                  = fifo_pc_q[rd_ptr_q];
      flush_out               = 1'b0;
    end
  end

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp_valid);
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pend_rd_d     = pend_rd_q;
    pend_wr_d     = pend_wr_q;

    if (issue) begin
      pc_d      = pc_q + 32'd4;
      pend_wr_d = pend_wr_q + PW'(1);
    end
    if (resp_valid) begin
      pend_rd_d = pend_rd_q + PW'(1);
    end
    if (resp_drop) begin
      drop_d = drop_q - CW'(1);
    end

    if (branch_taken_in) begin
      // Everything still in flight is stale; the same-cycle response already left outstanding_d.
      pc_d     = branch_target_in & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      drop_d   = outstanding_d;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pend_rd_q     <= '0;
      pend_wr_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pend_rd_q     <= pend_rd_d;
      pend_wr_q     <= pend_wr_d;
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers and counters mark every entry invalid.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (issue) begin
      pend_pc_q[pend_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pend_pc_q[pend_rd_q];
      fifo_data_q[wr_ptr_q] <= ms_riscv32_mp_instr_rdata_in;
    end
  end

endmodule

// File: tb/tb_msrv32_instr_fetch_buffer.sv
// Randomized scoreboard bench for msrv32_instr_fetch_buffer: a memory model answers
// fetches in order with variable latency, and a monitor checks the consumed stream.
module tb_msrv32_instr_fetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] target;
  logic        stall;
  logic [31:0] imaddr;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic        flush;

  msrv32_instr_fetch_buffer #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .branch_taken_in              (branch),
    .branch_target_in             (target),
    .stall_in                     (stall),
    .ms_riscv32_mp_imaddr_out     (imaddr),
    .ms_riscv32_mp_instr_req_out  (req),
    .ms_riscv32_mp_instr_gnt_in   (gnt),
    .ms_riscv32_mp_instr_rvalid_in(rvalid),
    .ms_riscv32_mp_instr_rdata_in (rdata),
    .ms_riscv32_mp_instr_out      (instr),
    .pc_out                       (pc_o),
    .flush_out                    (flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected instructions granted but not yet consumed, in program order.
  exp_t exp_q[$];
  // Requests the memory has accepted and still has to answer.
  mem_t mem_q[$];
  // In-flight responses belonging to fetches abandoned by a redirect.
  int          stale = 0;
  logic [31:0] model_pc;
  int          cyc = 0;
  int          last_due = 0;

  int          gnt_pct, stall_pct, br_pct, lat_min, lat_max;
  bit          br_pending = 1'b0;
  logic [31:0] br_target;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    mem_t m;
    bit   resp;
    int   due;
    @(negedge clk);
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m      = mem_q.pop_front();
      rvalid = 1'b1;
      rdata  = mem_fn(m.addr);
      resp   = 1'b1;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      resp   = 1'b0;
    end
    gnt   = ($urandom_range(99) < gnt_pct);
    stall = ($urandom_range(99) < stall_pct);
    if (br_pending) begin
      branch     = 1'b1;
      target     = br_target;
      br_pending = 1'b0;
    end else if ($urandom_range(99) < br_pct) begin
      branch = 1'b1;
      target = $urandom;
    end else begin
      branch = 1'b0;
      target = $urandom;
    end
    #1;
    check("req", {31'b0, req}, {31'b0, !branch && (exp_q.size() + stale < DEPTH)});
    if (resp && stale > 0) stale--;
    if (branch) begin
      exp_q.delete();
      stale    = mem_q.size();
      model_pc = target & 32'hFFFF_FFFC;
    end else if (req && gnt) begin
      check("imaddr", imaddr, model_pc);
      exp_q.push_back('{model_pc, mem_fn(model_pc)});
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{imaddr, due});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic do_reset(input int n, input bit late);
    @(negedge clk);
    rst        = 1'b1;
    branch     = 1'b0;
    stall      = 1'b0;
    gnt        = 1'($urandom_range(1));
    rvalid     = 1'($urandom_range(1));
    rdata      = $urandom;
    br_pending = 1'b0;
    #1;
    check("req during reset", {31'b0, req}, 32'd0);
    repeat (n - 1) begin
      @(negedge clk);
      gnt    = 1'($urandom_range(1));
      rvalid = 1'($urandom_range(1));
      rdata  = $urandom;
    end
    @(negedge clk);
    rst    = 1'b0;
    gnt    = 1'b0;
    rvalid = late;
    rdata  = 32'hBAD0_BAD0;
    exp_q.delete();
    mem_q.delete();
    stale    = 0;
    model_pc = RESET_PC;
    last_due = cyc;
    #1;
    check("reset flush", {31'b0, flush}, 32'd1);
    check("reset instr", instr, NOP);
    check("reset pc_out", pc_o, 32'h0);
    check("reset imaddr", imaddr, RESET_PC);
    check("reset req", {31'b0, req}, 32'd1);
  endtask

  // Monitor: every consumed instruction must be the next one the model expects.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      if (branch) begin
        check("redirect flush", {31'b0, flush}, 32'd1);
        check("redirect instr", instr, NOP);
      end else if (flush) begin
        check("empty instr", instr, NOP);
        check("empty pc_out", pc_o, 32'h0);
      end else if (!stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected instr flush", {31'b0, flush}, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pc_out", pc_o, e.pc);
          check("instr", instr, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; branch = 1'b0; target = '0; stall = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; model_pc = RESET_PC;
    gnt_pct = 100; stall_pct = 0; br_pct = 0; lat_min = 1; lat_max = 1;

    do_reset(3, 1'b0);
    // Single-cycle memory: first word two cycles after the first grant, then one per cycle.
    for (int k = 0; k < 9; k++) begin
      step();
      check("fill flush", {31'b0, flush}, (k >= 2) ? 32'd0 : 32'd1);
    end

    // Back pressure: occupancy saturates at DEPTH.
    stall_pct = 100;
    repeat (10) step();
    check("stall occupancy", exp_q.size(), DEPTH);
    stall_pct = 0;
    repeat (8) step();

    // Slow memory, then redirect onto an unaligned target.
    lat_min = 3; lat_max = 3;
    repeat (3) step();
    br_target = 32'h0000_0103; br_pending = 1'b1;
    repeat (14) step();

    // Address wrap past the top of memory.
    lat_min = 1; lat_max = 1;
    br_target = 32'hFFFF_FFFC; br_pending = 1'b1;
    repeat (10) step();

    // Reset with words buffered and in flight, plus a late response.
    lat_min = 2; lat_max = 2; stall_pct = 100;
    repeat (5) step();
    stall_pct = 0;
    do_reset(2, 1'b1);
    repeat (12) step();

    for (int r = 0; r < 40; r++) begin
      gnt_pct   = $urandom_range(100, 30);
      stall_pct = $urandom_range(60, 0);
      br_pct    = $urandom_range(10, 0);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      repeat (100) step();
      if ($urandom_range(3) == 0) do_reset($urandom_range(3, 1), 1'($urandom_range(1)));
    end

    // Drain: with no new fetches every expected word must come out.
    gnt_pct = 0; stall_pct = 0; br_pct = 0;
    repeat (30) step();
    check("drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
